// File: rtl/g18_arbiter_if.sv
// g18_arbiter_if
//   Bundles the requester handshakes, the shared read-data return and the
//   G18 flash pad signals of g18_arbiter.
//   slave  : arbiter view (requests and flash data in; acks, data, flash strobes out)
//   master : requester/flash view (the mirror image)
//   Signals: req0_i/req1_i, adr0_i/adr1_i, len0_i/len1_i  - per-port burst requests
//            ack0_o/ack1_o, vld0_o/vld1_o                 - per-port accept / data pulses
//            rd_dat_o, last_o, busy_o                      - shared read return and status
//            g18_adr_o, g18_rd_o, g18_dat_i                - flash word address, strobe, data
`timescale 1ns/1ps
interface g18_arbiter_if #(
    parameter int ADR_W = 23,
    parameter int DAT_W = 16
);
    logic             req0_i;
    logic             req1_i;
    logic [ADR_W-1:0] adr0_i;
    logic [ADR_W-1:0] adr1_i;
    logic [1:0]       len0_i;
    logic [1:0]       len1_i;
    logic             ack0_o;
    logic             ack1_o;
    logic             vld0_o;
    logic             vld1_o;
    logic [DAT_W-1:0] rd_dat_o;
    logic             last_o;
    logic             busy_o;
    logic [ADR_W-1:0] g18_adr_o;
    logic             g18_rd_o;
    logic [DAT_W-1:0] g18_dat_i;

    modport slave (
        input  req0_i, req1_i, adr0_i, adr1_i, len0_i, len1_i, g18_dat_i,
        output ack0_o, ack1_o, vld0_o, vld1_o, rd_dat_o, last_o, busy_o,
               g18_adr_o, g18_rd_o
    );

    modport master (
        output req0_i, req1_i, adr0_i, adr1_i, len0_i, len1_i, g18_dat_i,
        input  ack0_o, ack1_o, vld0_o, vld1_o, rd_dat_o, last_o, busy_o,
               g18_adr_o, g18_rd_o
    );
endinterface

// File: rtl/g18_arbiter.sv
// g18_arbiter
//   Two-requester round-robin read arbiter and word sequencer for the G18
//   BPI flash port. Grants one 1..4 word incrementing burst at a time and
//   holds each word address with the read strobe high for WAIT_CYCLES clocks.
//   Ports:
//     sys_clk_i   - system clock
//     sys_rst_n_i - asynchronous active-low reset
//     bus         - g18_arbiter_if.slave: requests, acks, read data, flash pads
`timescale 1ns/1ps
module g18_arbiter #(
    parameter int ADR_W       = 23,
    parameter int DAT_W       = 16,
    parameter int WAIT_CYCLES = 4
) (
    input  logic           sys_clk_i,
    input  logic           sys_rst_n_i,
    g18_arbiter_if.slave   bus
);

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    typedef enum logic {
        ST_IDLE,
        ST_READ
    } state_t;

    state_t           state_q, state_d;
    logic             last_gnt_q, last_gnt_d;
    logic             port_q, port_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [1:0]       rem_q, rem_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [DAT_W-1:0] rd_dat_q, rd_dat_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             vld0_q, vld0_d;
    logic             vld1_q, vld1_d;
    logic             last_q, last_d;

    logic             gnt_any;
    logic             gnt_sel;

    // Port 0 wins unless only port 1 asks, or both ask and port 0 was
    // granted last time; gnt_sel is the granted port index.
    always_comb begin
        gnt_any = bus.req0_i | bus.req1_i;
        gnt_sel = bus.req1_i & ~(bus.req0_i & last_gnt_q);
    end

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        port_d     = port_q;
        adr_d      = adr_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        rd_dat_d   = rd_dat_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        vld0_d     = 1'b0;
        vld1_d     = 1'b0;
        last_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    ack0_d     = ~gnt_sel;
                    ack1_d     = gnt_sel;
                    port_d     = gnt_sel;
                    last_gnt_d = gnt_sel;
                    adr_d      = gnt_sel ? bus.adr1_i : bus.adr0_i;
                    rem_d      = gnt_sel ? bus.len1_i : bus.len0_i;
                    cnt_d      = CNT_INIT;
                    state_d    = ST_READ;
                end
            end
            ST_READ: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rd_dat_d = bus.g18_dat_i;
                    vld0_d   = ~port_q;
                    vld1_d   = port_q;
                    if (rem_q == '0) begin
                        last_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        // Natural wrap of the ADR_W-bit sum gives modulo addressing.
                        adr_d = adr_q + ADR_W'(1);
                        rem_d = rem_q - 2'd1;
                        cnt_d = CNT_INIT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            state_q    <= ST_IDLE;
            last_gnt_q <= 1'b1;
            port_q     <= 1'b0;
            adr_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            rd_dat_q   <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            vld0_q     <= 1'b0;
            vld1_q     <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            port_q     <= port_d;
            adr_q      <= adr_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            rd_dat_q   <= rd_dat_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            vld0_q     <= vld0_d;
            vld1_q     <= vld1_d;
            last_q     <= last_d;
        end
    end

    assign bus.ack0_o    = ack0_q;
    assign bus.ack1_o    = ack1_q;
    assign bus.vld0_o    = vld0_q;
    assign bus.vld1_o    = vld1_q;
    assign bus.rd_dat_o  = rd_dat_q;
    assign bus.last_o    = last_q;
    assign bus.busy_o    = (state_q != ST_IDLE);
    assign bus.g18_adr_o = adr_q;
    assign bus.g18_rd_o  = (state_q == ST_READ);

endmodule
